imem_loader: RTL and testbench

Instruction-memory writer for the mini MIPS core: accepts one instruction per handshake as a mnemonic select plus register/immediate/address fields, encodes it into the 32-bit MIPS word that the core's instruction decoder consumes, and writes it to consecutive instruction-memory locations. It sits between the test/host side and instruction memory and holds the CPU in reset until the program is sealed.

---
 rtl/imem_loader.sv | 176 +++++++++++++++++
 tb/tb_imem_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory writer for the mini MIPS core: encodes one mnemonic plus fields per
// handshake into a 32-bit MIPS word and writes it to consecutive imem locations.
module imem_loader #(
  parameter int unsigned          ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op_sel,
  input  logic [4:0]        f_rs,
  input  logic [4:0]        f_rt,
  input  logic [4:0]        f_rd,
  input  logic [4:0]        f_shamt,
  input  logic [15:0]       f_imm,
  input  logic [25:0]       f_addr,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err_invalid,
  output logic              cpu_rst_n
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_ADDU  = 5'd1,  OP_SUB  = 5'd2,  OP_SUBU = 5'd3,
    OP_AND  = 5'd4,  OP_OR    = 5'd5,  OP_XOR  = 5'd6,  OP_SLT  = 5'd7,
    OP_SLL  = 5'd8,  OP_SRL   = 5'd9,  OP_SRA  = 5'd10, OP_JR   = 5'd11,
    OP_ADDI = 5'd12, OP_ADDIU = 5'd13, OP_ANDI = 5'd14, OP_ORI  = 5'd15,
    OP_XORI = 5'd16, OP_SLTI  = 5'd17, OP_LUI  = 5'd18, OP_LW   = 5'd19,
    OP_SW   = 5'd20, OP_BEQ   = 5'd21, OP_BNE  = 5'd22, OP_J    = 5'd23,
    OP_JAL  = 5'd24
  } op_e;

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [ADDR_W:0]  word_count_q, word_count_d;
  logic             err_invalid_q, err_invalid_d;
  logic             fin_pend_q, fin_pend_d;
  logic [31:0]      imem_wdata_q, imem_wdata_d;

  logic             accept;
  logic             enc_valid;
  logic [31:0]      enc_word;

  // Instruction encoder; field forcing zeroes operands the decoder must see as 0.
  always_comb begin
    logic [5:0] funct;
    logic [5:0] opcode;
    logic [4:0] rs, rt, rd, sh;
    enc_valid = 1'b1;
    enc_word  = '0;
    funct     = '0;
    opcode    = '0;
    rs        = f_rs;
    rt        = f_rt;
    rd        = f_rd;
    sh        = '0;
    case (op_e'(op_sel))
      OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_SLT,
      OP_SLL, OP_SRL, OP_SRA, OP_JR: begin
        case (op_e'(op_sel))
          OP_ADD:  funct = 6'h20;
          OP_ADDU: funct = 6'h21;
          OP_SUB:  funct = 6'h22;
          OP_SUBU: funct = 6'h23;
          OP_AND:  funct = 6'h24;
          OP_OR:   funct = 6'h25;
          OP_XOR:  funct = 6'h26;
          OP_SLT:  funct = 6'h2A;
          OP_SLL:  begin funct = 6'h00; rs = '0; sh = f_shamt; end
          OP_SRL:  begin funct = 6'h02; rs = '0; sh = f_shamt; end
          OP_SRA:  begin funct = 6'h03; rs = '0; sh = f_shamt; end
          default: begin funct = 6'h08; rt = '0; rd = '0; end
        endcase
        enc_word = {6'h00, rs, rt, rd, sh, funct};
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI,
      OP_LW, OP_SW, OP_BEQ, OP_BNE: begin
        case (op_e'(op_sel))
          OP_ADDI:  opcode = 6'h08;
          OP_ADDIU: opcode = 6'h09;
          OP_ANDI:  opcode = 6'h0C;
          OP_ORI:   opcode = 6'h0D;
          OP_XORI:  opcode = 6'h0E;
          OP_SLTI:  opcode = 6'h0A;
          OP_LUI:   begin opcode = 6'h0F; rs = '0; end
          OP_LW:    opcode = 6'h23;
          OP_SW:    opcode = 6'h2B;
          OP_BEQ:   opcode = 6'h04;
          default:  opcode = 6'h05;
        endcase
        enc_word = {opcode, rs, rt, f_imm};
      end
      OP_J:    enc_word = {6'h02, f_addr};
      OP_JAL:  enc_word = {6'h03, f_addr};
      default: enc_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    word_count_d  = word_count_q;
    err_invalid_d = err_invalid_q;
    fin_pend_d    = fin_pend_q;
    imem_wdata_d  = imem_wdata_q;
    imem_we       = 1'b0;
    full          = (word_count_q == CAPACITY);
    in_ready      = (state_q == S_LOAD) && !full;
    accept        = in_valid && in_ready;

    // start overrides everything, including the strobe of an in-flight WRITE.
    if (start) begin
      state_d       = S_LOAD;
      word_count_d  = '0;
      err_invalid_d = 1'b0;
      fin_pend_d    = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (accept && enc_valid) begin
            state_d      = S_WRITE;
            imem_wdata_d = enc_word;
            fin_pend_d   = finish;
          end else begin
            if (accept) err_invalid_d = 1'b1;
            if (finish) state_d = S_DONE;
          end
        end
        S_WRITE: begin
          imem_we      = 1'b1;
          word_count_d = word_count_q + ONE;
          fin_pend_d   = 1'b0;
          state_d      = (fin_pend_q || finish) ? S_DONE : S_LOAD;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      word_count_q  <= '0;
      err_invalid_q <= 1'b0;
      fin_pend_q    <= 1'b0;
      imem_wdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      word_count_q  <= word_count_d;
      err_invalid_q <= err_invalid_d;
      fin_pend_q    <= fin_pend_d;
      imem_wdata_q  <= imem_wdata_d;
    end
  end

  assign imem_addr   = BASE_ADDR + word_count_q[ADDR_W-1:0];
  assign imem_wdata  = imem_wdata_q;
  assign word_count  = word_count_q;
  assign err_invalid = err_invalid_q;
  assign cpu_rst_n   = (state_q == S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-size instance plus a 4-word instance
// (BASE_ADDR 1) share the stimulus; expected words are hand-encoded MIPS.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, finish, in_valid;
  logic [4:0]  op_sel, f_rs, f_rt, f_rd, f_shamt;
  logic [15:0] f_imm;
  logic [25:0] f_addr;

  logic        in_ready, imem_we, full, err_invalid, cpu_rst_n;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  word_count;

  logic        in_ready_b, imem_we_b, full_b, err_invalid_b, cpu_rst_n_b;
  logic [1:0]  imem_addr_b;
  logic [31:0] imem_wdata_b;
  logic [2:0]  word_count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_loader u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel),
    .f_rs(f_rs), .f_rt(f_rt), .f_rd(f_rd), .f_shamt(f_shamt),
    .f_imm(f_imm), .f_addr(f_addr), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .word_count(word_count), .full(full), .err_invalid(err_invalid),
    .cpu_rst_n(cpu_rst_n)
  );

  imem_loader #(.ADDR_W(2), .BASE_ADDR(2'd1)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready_b), .op_sel(op_sel),
    .f_rs(f_rs), .f_rt(f_rt), .f_rd(f_rd), .f_shamt(f_shamt),
    .f_imm(f_imm), .f_addr(f_addr), .imem_we(imem_we_b),
    .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b),
    .word_count(word_count_b), .full(full_b), .err_invalid(err_invalid_b),
    .cpu_rst_n(cpu_rst_n_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] addr);
    op_sel = op; f_rs = rs; f_rt = rt; f_rd = rd; f_shamt = sh; f_imm = imm; f_addr = addr;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_addr_b [4];
    exp_addr_b = '{2'd1, 2'd2, 2'd3, 2'd0};

    rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    op_sel = '0; f_rs = '0; f_rt = '0; f_rd = '0; f_shamt = '0; f_imm = '0; f_addr = '0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_count", word_count, 0);
    chk("rst_full", full, 0);
    chk("rst_err", err_invalid, 0);
    chk("rst_cpu", cpu_rst_n, 0);
    chk("rst_addr_b", imem_addr_b, 1);
    rst_n = 1'b1;
    tick();

    // finish while idle is ignored
    finish = 1'b1; tick(); finish = 1'b0;
    chk("idle_finish_cpu", cpu_rst_n, 0);
    chk("idle_in_ready", in_ready, 0);

    pulse_start();
    chk("load_in_ready", in_ready, 1);

    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, '0);
    chk("add_we", imem_we, 1);
    chk("add_addr", imem_addr, 0);
    chk("add_wdata", imem_wdata, 32'h00221820);
    chk("add_busy", in_ready, 0);
    tick();
    chk("add_we_drop", imem_we, 0);
    chk("add_count", word_count, 1);

    pulse_start();
    chk("restart_count", word_count, 0);
    send(5'd12, 5'd0, 5'd2, 5'd0, 5'd0, 16'd5, '0);
    chk("addi_addr", imem_addr, 0);
    chk("addi_wdata", imem_wdata, 32'h20020005);
    tick();
    send(5'd19, 5'd29, 5'd4, 5'd0, 5'd0, 16'd8, '0);
    chk("lw_addr", imem_addr, 1);
    chk("lw_wdata", imem_wdata, 32'h8FA40008);
    tick();
    send(5'd8, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, '0);
    chk("sll_addr", imem_addr, 2);
    chk("sll_wdata", imem_wdata, 32'h00011100);
    tick();
    send(5'd23, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
    chk("j_wdata", imem_wdata, 32'h08000010);
    tick();
    send(5'd11, 5'd31, 5'd5, 5'd6, 5'd7, 16'h0, '0);
    chk("jr_wdata", imem_wdata, 32'h03E00008);
    tick();
    send(5'd18, 5'd3, 5'd8, 5'd0, 5'd0, 16'h1234, '0);
    chk("lui_wdata", imem_wdata, 32'h3C081234);
    tick();
    send(5'd2, 5'd1, 5'd2, 5'd3, 5'd5, 16'h0, '0);
    chk("sub_addr", imem_addr, 6);
    chk("sub_wdata", imem_wdata, 32'h00221822);
    tick();
    chk("count7", word_count, 7);

    // invalid mnemonic: handshake completes, nothing written
    chk("inv_ready", in_ready, 1);
    send(5'd27, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, '0);
    chk("inv_we", imem_we, 0);
    chk("inv_err", err_invalid, 1);
    chk("inv_ready_after", in_ready, 1);
    chk("inv_count", word_count, 7);

    // accept together with finish: written, then DONE
    finish = 1'b1;
    send(5'd13, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, '0);
    finish = 1'b0;
    chk("fin_we", imem_we, 1);
    chk("fin_addr", imem_addr, 7);
    chk("fin_wdata", imem_wdata, 32'h2422FFFF);
    chk("fin_cpu_low", cpu_rst_n, 0);
    tick();
    chk("done_cpu", cpu_rst_n, 1);
    chk("done_count", word_count, 8);
    chk("done_ready", in_ready, 0);
    chk("done_err_sticky", err_invalid, 1);
    finish = 1'b1; tick(); finish = 1'b0;
    chk("done_finish_cpu", cpu_rst_n, 1);

    pulse_start();
    chk("start_cpu_low", cpu_rst_n, 0);
    chk("start_err_clr", err_invalid, 0);
    chk("start_count_clr", word_count, 0);

    // start during WRITE aborts the strobe
    send(5'd15, 5'd0, 5'd1, 5'd0, 5'd0, 16'h00FF, '0);
    chk("abort_pre_we", imem_we, 1);
    start = 1'b1;
    #1;
    chk("abort_we", imem_we, 0);
    tick();
    start = 1'b0;
    chk("abort_count", word_count, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_cpu", cpu_rst_n, 0);

    // small instance: fill, wrap, saturate
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send(5'd1, 5'(i), 5'd2, 5'd3, 5'd0, 16'h0, '0);
      chk("small_we", imem_we_b, 1);
      chk("small_addr", imem_addr_b, exp_addr_b[i]);
      tick();
    end
    chk("small_count", word_count_b, 4);
    chk("small_full", full_b, 1);
    chk("small_ready", in_ready_b, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("small_ignore_we", imem_we_b, 0);
    chk("small_ignore_count", word_count_b, 4);
    finish = 1'b1; tick(); finish = 1'b0;
    chk("small_cpu", cpu_rst_n_b, 1);

    // async reset mid-WRITE
    pulse_start();
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, '0);
    chk("arst_pre_we", imem_we, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_we", imem_we, 0);
    chk("arst_count", word_count, 0);
    chk("arst_wdata", imem_wdata, 0);
    chk("arst_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_after_count", word_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
